// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the pixel-painting pipeline.
// Two free-running counters walk the full raster (visible area, porches and
// sync). Every output is a registered decode of the counter values from one
// clock earlier, so col/row/disp_ena/syncs/frame_tick all stay aligned.
//
// Ports:
//   clk        in   pixel clock, rising edge
//   reset_n    in   synchronous reset, active low
//   col        out  [9:0] visible column, 0 outside the visible area
//   row        out  [8:0] visible row, 0 outside the visible area
//   disp_ena   out  high while the pixel is visible
//   h_sync     out  horizontal sync, active level H_POL
//   v_sync     out  vertical sync, active level V_POL
//   frame_tick out  one-clock pulse at pixel (0,0) of every frame
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       disp_ena,
  output logic       h_sync,
  output logic       v_sync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits wide so that a visible width of 1024 still
  // compares correctly against the zero-extended 10-bit counters.
  localparam logic [10:0] H_VIS_W = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W = 11'(V_VISIBLE);
  localparam logic [10:0] H_SS_W  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SE_W  = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_SS_W  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SE_W  = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] col_q, col_d;
  logic [8:0] row_q, row_d;
  logic       de_q, de_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       ft_q, ft_d;

  logic [10:0] h_ext, v_ext;
  logic        h_end, v_end;

  always_comb begin
    h_ext = {1'b0, h_cnt_q};
    v_ext = {1'b0, v_cnt_q};
    h_end = (h_cnt_q == H_LAST);
    v_end = (v_cnt_q == V_LAST);

    // Counter advance: the vertical counter only moves on the last pixel
    // of a line.
    h_cnt_d = h_end ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_end) v_cnt_d = v_end ? '0 : v_cnt_q + 10'd1;

    // Decode of the current (pre-edge) position.
    de_d  = (h_ext < H_VIS_W) && (v_ext < V_VIS_W);
    col_d = de_d ? h_cnt_q      : '0;
    row_d = de_d ? v_cnt_q[8:0] : '0;
    hs_d  = ((h_ext >= H_SS_W) && (h_ext < H_SE_W)) ? H_POL : ~H_POL;
    vs_d  = ((v_ext >= V_SS_W) && (v_ext < V_SE_W)) ? V_POL : ~V_POL;
    ft_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      ft_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ft_q    <= ft_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign disp_ena   = de_q;
  assign h_sync     = hs_q;
  assign v_sync     = vs_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a shrunken raster so that whole frames run
// quickly. The reference model only knows how many clocks have passed since
// reset release and derives the expected pixel from that count.
module tb_vga_sync_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 24
  localparam int VT = VV + VF + VS + VB;   // 17
  localparam int FRAME = HT * VT;          // 408

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0] d_col, p_col;
  logic [8:0] d_row, p_row;
  logic d_de, d_hs, d_vs, d_ft;
  logic p_de, p_hs, p_vs, p_ft;

  int errors = 0;
  int checks = 0;

  // Clocks since release: -1 while in reset, 0 on the first released edge.
  longint n = -1;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .col(d_col), .row(d_row),
    .disp_ena(d_de), .h_sync(d_hs), .v_sync(d_vs), .frame_tick(d_ft)
  );

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_pol (
    .clk(clk), .reset_n(reset_n), .col(p_col), .row(p_row),
    .disp_ena(p_de), .h_sync(p_hs), .v_sync(p_vs), .frame_tick(p_ft)
  );

  always #5 clk = ~clk;

  always @(posedge clk) n <= reset_n ? n + 1 : -1;

  function automatic exp_t model(longint k, bit pol);
    exp_t e;
    longint p, h, v;
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    if (k >= 0) begin
      p = k % FRAME;
      h = p % HT;
      v = p / HT;
      e.de = (h < HV) && (v < VV);
      if (e.de) begin
        e.col = 10'(h);
        e.row = 9'(v);
      end
      e.hs = (h >= HV + HF && h < HV + HF + HS) ? pol : ~pol;
      e.vs = (v >= VV + VF && v < VV + VF + VS) ? pol : ~pol;
      e.ft = (p == 0);
    end
    return e;
  endfunction

  function automatic exp_t act_d();
    return exp_t'({d_col, d_row, d_de, d_hs, d_vs, d_ft});
  endfunction

  function automatic exp_t act_p();
    return exp_t'({p_col, p_row, p_de, p_hs, p_vs, p_ft});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    reset_n = 1'b0;
    repeat (cycles) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (act_d() !== exp_t'({10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0})) begin
        errors++;
        $display("FAIL reset_dflt cyc=%0d got=%h want col0 row0 de0 hs1 vs1 ft0", i, act_d());
      end
      checks++;
      if ({p_hs, p_vs, p_de, p_ft} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_pol cyc=%0d got hs=%b vs=%b de=%b ft=%b want 0000", i, p_hs, p_vs, p_de, p_ft);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_line();
    exp_t w;
    for (int k = 0; k <= HT; k++) begin
      step();
      w = '0;
      w.hs = !(k >= HV + HF && k < HV + HF + HS);
      w.vs = 1'b1;
      if (k < HV) begin
        w.de = 1'b1;
        w.col = 10'(k);
      end
      if (k == HT) begin
        w.de = 1'b1;
        w.row = 9'd1;
        w.hs = 1'b1;
      end
      w.ft = (k == 0);
      checks++;
      if (act_d() !== w) begin
        errors++;
        $display("FAIL first_line k=%0d got=%h want=%h", k, act_d(), w);
      end
    end
  endtask

  task automatic test_hsync();
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    do_reset(2);
    for (int k = 0; k < HT; k++) begin
      step();
      if (d_hs === 1'b0) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    checks++;
    if (cnt !== HS || first !== HV + HF || last !== HV + HF + HS - 1) begin
      errors++;
      $display("FAIL hsync_window got cnt=%0d first=%0d last=%0d want %0d %0d %0d",
               cnt, first, last, HS, HV + HF, HV + HF + HS - 1);
    end
  endtask

  task automatic test_frames();
    int ft_cnt, ft0, ft1, de_cnt, vs_tot, run, max_run, vs_first;
    ft_cnt = 0; ft0 = -1; ft1 = -1; de_cnt = 0; vs_tot = 0; run = 0; max_run = 0; vs_first = -1;
    do_reset(1);
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      checks++;
      if (act_d() !== model(n, 1'b0)) begin
        errors++;
        $display("FAIL frame_px k=%0d got=%h want=%h", k, act_d(), model(n, 1'b0));
      end
      if (d_ft === 1'b1) begin
        if (ft_cnt == 0) ft0 = k; else ft1 = k;
        ft_cnt++;
      end
      if (d_de === 1'b1) de_cnt++;
      if (d_vs === 1'b0) begin
        vs_tot++; run++;
        if (vs_first < 0) vs_first = k;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
    checks++;
    if (ft_cnt !== 2 || ft1 - ft0 !== FRAME) begin
      errors++;
      $display("FAIL frame_tick got cnt=%0d gap=%0d want 2 %0d", ft_cnt, ft1 - ft0, FRAME);
    end
    checks++;
    if (de_cnt !== 2 * HV * VV) begin
      errors++;
      $display("FAIL disp_count got=%0d want=%0d", de_cnt, 2 * HV * VV);
    end
    checks++;
    if (vs_tot !== 2 * VS * HT || max_run !== VS * HT || vs_first !== (VV + VF) * HT) begin
      errors++;
      $display("FAIL vsync_window got tot=%0d run=%0d first=%0d want %0d %0d %0d",
               vs_tot, max_run, vs_first, 2 * VS * HT, VS * HT, (VV + VF) * HT);
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    // Park at line 5, column 7 of the shrunken raster.
    while ((n < 0 || (n % FRAME) != 5 * HT + 7) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    checks++;
    if (act_d() !== exp_t'({10'd7, 9'd5, 1'b1, 1'b1, 1'b1, 1'b0})) begin
      errors++;
      $display("FAIL mid_park got=%h want col7 row5 de1", act_d());
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (act_d() !== exp_t'({10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0})) begin
      errors++;
      $display("FAIL mid_reset got=%h want reset values", act_d());
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (act_d() !== exp_t'({10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1}) || p_vs !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart got=%h pol_vs=%b want col0 row0 de1 hs1 vs1 ft1, pol_vs0", act_d(), p_vs);
    end
    for (int k = 1; k < 40; k++) begin
      step();
      checks++;
      if (act_d() !== model(n, 1'b0)) begin
        errors++;
        $display("FAIL mid_resume k=%0d got=%h want=%h", k, act_d(), model(n, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    int len, rlen;
    for (int it = 0; it < 20; it++) begin
      len = int'($urandom_range(1, 500));
      for (int k = 0; k < len; k++) begin
        step();
        checks++;
        if (act_d() !== model(n, 1'b0) || act_p() !== model(n, 1'b1)) begin
          errors++;
          $display("FAIL random it=%0d n=%0d got=%h/%h want=%h/%h", it, n,
                   act_d(), act_p(), model(n, 1'b0), model(n, 1'b1));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        rlen = int'($urandom_range(1, 3));
        reset_n = 1'b0;
        for (int k = 0; k < rlen; k++) begin
          step();
          checks++;
          if (act_d() !== model(n, 1'b0) || act_p() !== model(n, 1'b1)) begin
            errors++;
            $display("FAIL random_rst it=%0d got=%h/%h want=%h/%h", it,
                     act_d(), act_p(), model(n, 1'b0), model(n, 1'b1));
          end
        end
        reset_n = 1'b1;
      end
    end
  endtask

  task automatic test_polarity();
    int hs_hi, vs_hi;
    hs_hi = 0; vs_hi = 0;
    do_reset(1);
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (p_hs === 1'b1) hs_hi++;
      if (p_vs === 1'b1) vs_hi++;
      checks++;
      if (act_p() !== model(n, 1'b1)) begin
        errors++;
        $display("FAIL pol_px k=%0d got=%h want=%h", k, act_p(), model(n, 1'b1));
      end
    end
    checks++;
    if (hs_hi !== HS * VT || vs_hi !== VS * HT) begin
      errors++;
      $display("FAIL pol_windows got hs_hi=%0d vs_hi=%0d want %0d %0d", hs_hi, vs_hi, HS * VT, VS * HT);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_hsync();
    test_frames();
    test_mid_reset();
    test_random();
    test_polarity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
